// File: rtl/muxn_scan.sv
// N-channel registered mux with manual select and a dwell-timed channel scanner.
// Optional MUXN_SCAN_MASK_EN adds a per-channel mask that removes channels from the scan order.
module muxn_scan #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int DWELL = 1,
  localparam int SW   = $clog2(N)
) (
  input  logic           clk,
  input  logic           n_reset,
  input  logic [N*W-1:0] x,
  input  logic [SW-1:0]  sel,
  input  logic           mode,
  input  logic           en,
`ifdef MUXN_SCAN_MASK_EN
  input  logic [N-1:0]   mask,
`endif
  output logic [W-1:0]   y,
  output logic [SW-1:0]  ch,
  output logic           valid,
  output logic           wrap
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'(DWELL - 1);

  typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

  state_t         state, state_p0;
  logic [SW-1:0]  idx, idx_p0;
  logic [DCW-1:0] dcnt, dcnt_p0;
  logic           pend, pend_p0;
  logic [W-1:0]   y_p0;
  logic [SW-1:0]  ch_p0;
  logic           vld_p0;
  logic           wrap_p0;
  logic [N-1:0]   scan_mask;
  logic [SW:0]    hit, nxt;
  logic [SW-1:0]  eff;

`ifdef MUXN_SCAN_MASK_EN
  assign scan_mask = mask;
`else
  assign scan_mask = '0;
`endif

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d, input int k);
    return d[k*W +: W];
  endfunction

  // Returns {found, index} of the first unmasked channel searching upward from
  // 'from' with wrap-around; 'incl' decides whether 'from' itself is a candidate.
  function automatic logic [SW:0] find_open(input logic [N-1:0] m,
                                            input logic [SW-1:0] from,
                                            input logic incl);
    logic [SW:0] r;
    int j;
    r = '0;
    for (int o = N; o >= 0; o--) begin
      if ((o > 0 || incl) && (o < N || !incl)) begin
        j = (int'(from) + o) % N;
        if (!m[j]) r = {1'b1, SW'(j)};
      end
    end
    return r;
  endfunction

  // p0: next-state and next-output decode
  always_comb begin
    state_p0 = state;
    idx_p0   = idx;
    dcnt_p0  = dcnt;
    pend_p0  = pend;
    y_p0     = y;
    ch_p0    = ch;
    vld_p0   = valid;
    wrap_p0  = 1'b0;
    hit      = '0;
    nxt      = '0;
    eff      = '0;
    if (en) begin
      state_p0 = mode ? SCAN : MANUAL;
      if (state != IDLE) begin
        if (!mode) begin
          ch_p0   = sel;
          idx_p0  = '0;
          dcnt_p0 = '0;
          pend_p0 = 1'b0;
          if (int'(sel) < N) begin
            y_p0   = pick(x, int'(sel));
            vld_p0 = 1'b1;
          end else begin
            y_p0   = '0;
            vld_p0 = 1'b0;
          end
        end else begin
          hit = find_open(scan_mask, idx, 1'b1);
          if (!hit[SW]) begin
            y_p0   = '0;
            ch_p0  = idx;
            vld_p0 = 1'b0;
          end else begin
            eff     = hit[SW-1:0];
            y_p0    = pick(x, int'(eff));
            ch_p0   = eff;
            vld_p0  = 1'b1;
            // A wrap recorded on the previous advance is reported alongside
            // the first sample of the new pass.
            wrap_p0 = pend;
            pend_p0 = 1'b0;
            idx_p0  = eff;
            if (dcnt == DLAST) begin
              nxt     = find_open(scan_mask, eff, 1'b0);
              idx_p0  = nxt[SW-1:0];
              dcnt_p0 = '0;
              pend_p0 = (nxt[SW-1:0] <= eff) || (eff < idx);
            end else begin
              dcnt_p0 = dcnt + 1'b1;
            end
          end
        end
      end
    end
  end

  // p1: registered outputs and scan state
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= IDLE;
      idx   <= '0;
      dcnt  <= '0;
      pend  <= 1'b0;
      y     <= '0;
      ch    <= '0;
      valid <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_p0;
      idx   <= idx_p0;
      dcnt  <= dcnt_p0;
      pend  <= pend_p0;
      y     <= y_p0;
      ch    <= ch_p0;
      valid <= vld_p0;
      wrap  <= wrap_p0;
    end
  end

endmodule

// File: tb/tb_muxn_scan.sv
// Self-checking bench for muxn_scan: directed literal checks plus randomized
// stimulus compared every cycle against a scan-order/sample-count model.
module tb_muxn_scan;
  localparam int N = 6, W = 8, DWELL = 2, SW = $clog2(N);

  logic           clk = 1'b0;
  logic           n_reset, mode, en;
  logic [N*W-1:0] x;
  logic [SW-1:0]  sel;
  logic [N-1:0]   m_mask;
  logic [W-1:0]   y;
  logic [SW-1:0]  ch;
  logic           valid, wrap;

  logic [W-1:0]   e_y;
  logic [SW-1:0]  e_ch;
  logic           e_valid, e_wrap;
  int             m_st;   // 0 idle, 1 manual, 2 scan
  int             m_n;    // scan samples taken since entering scan
  bit             chk_on = 1'b0;
  int             total = 0, bad = 0;
  logic           mode_r;

  muxn_scan #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .clk(clk), .n_reset(n_reset), .x(x), .sel(sel), .mode(mode), .en(en),
`ifdef MUXN_SCAN_MASK_EN
    .mask(m_mask),
`endif
    .y(y), .ch(ch), .valid(valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Expected outputs after the coming edge, from the current inputs.
  task automatic step_model();
    int order[$];
    int k, c;
    if (!n_reset) begin
      e_y = '0; e_ch = '0; e_valid = 1'b0; e_wrap = 1'b0; m_st = 0; m_n = 0;
    end else if (!en) begin
      e_wrap = 1'b0;
    end else if (m_st == 0) begin
      m_st = mode ? 2 : 1; m_n = 0; e_wrap = 1'b0;
    end else if (!mode) begin
      m_st = 1; m_n = 0; e_wrap = 1'b0; e_ch = sel;
      if (int'(sel) < N) begin e_y = x[int'(sel)*W +: W]; e_valid = 1'b1; end
      else begin e_y = '0; e_valid = 1'b0; end
    end else begin
      m_st = 2;
      for (int i = 0; i < N; i++) if (!m_mask[i]) order.push_back(i);
      if (order.size() == 0) begin
        e_y = '0; e_ch = '0; e_valid = 1'b0; e_wrap = 1'b0;
      end else begin
        k = m_n / DWELL;
        c = order[k % order.size()];
        e_y = x[c*W +: W]; e_ch = SW'(c); e_valid = 1'b1;
        e_wrap = (m_n > 0) && (m_n % DWELL == 0) && (k % order.size() == 0);
        m_n++;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if ({y, ch, valid, wrap} !== {e_y, e_ch, e_valid, e_wrap}) begin
        bad++;
        $display("FAIL model t=%0t: y=%h ch=%0d valid=%b wrap=%b, expected y=%h ch=%0d valid=%b wrap=%b",
                 $time, y, ch, valid, wrap, e_y, e_ch, e_valid, e_wrap);
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic rn, input logic e, input logic md, input logic [SW-1:0] s);
    tick();
    n_reset = rn; en = e; mode = md; sel = s;
    step_model();
  endtask

  task automatic peek(input string nm, input logic [W-1:0] ey, input logic [SW-1:0] ec,
                      input logic ev, input logic ew);
    @(posedge clk); #1;
    total++;
    if ({y, ch, valid, wrap} !== {ey, ec, ev, ew}) begin
      bad++;
      $display("FAIL %s: got y=%h ch=%0d valid=%b wrap=%b, want y=%h ch=%0d valid=%b wrap=%b",
               nm, y, ch, valid, wrap, ey, ec, ev, ew);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) x[k*W +: W] = W'(8'h10 + k);
    n_reset = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; m_mask = '0;
    step_model();
    @(posedge clk); #1;
    chk_on = 1'b1;
    total++;
    if ({y, ch, valid, wrap} !== '0) begin
      bad++;
      $display("FAIL reset: got y=%h ch=%0d valid=%b wrap=%b, want all zero", y, ch, valid, wrap);
    end

    drive(1, 1, 0, 3); peek("idle_exit", 8'h00, 0, 0, 0);
    drive(1, 1, 0, 3); peek("man_sel3", 8'h13, 3, 1, 0);
    drive(1, 1, 0, 0); peek("man_sel0", 8'h10, 0, 1, 0);
    drive(1, 1, 0, 6); peek("man_oob", 8'h00, 6, 0, 0);
    drive(1, 1, 1, 0); peek("scan_first", 8'h10, 0, 1, 0);
    for (int i = 0; i < 11; i++) drive(1, 1, 1, 0);
    peek("scan_ch5", 8'h15, 5, 1, 0);
    drive(1, 1, 1, 0); peek("scan_wrap", 8'h10, 0, 1, 1);
    for (int i = 0; i < 5; i++) drive(1, 0, 1, 0);
    peek("en_hold", 8'h10, 0, 1, 0);
    drive(1, 1, 1, 0); peek("resume", 8'h10, 0, 1, 0);
    drive(1, 1, 1, 0); peek("resume_adv", 8'h11, 1, 1, 0);
    drive(1, 1, 0, 1); peek("to_manual", 8'h11, 1, 1, 0);
    drive(1, 1, 1, 0); peek("rescan", 8'h10, 0, 1, 0);
    drive(0, 1, 1, 0); peek("reset_mid", 8'h00, 0, 0, 0);

`ifdef MUXN_SCAN_MASK_EN
    m_mask = 6'b010101;
    drive(1, 1, 1, 0);
    drive(1, 1, 1, 0); peek("mask_first", 8'h11, 1, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 1, 1, 0);
    peek("mask_ch5", 8'h15, 5, 1, 0);
    drive(1, 1, 1, 0); peek("mask_wrap", 8'h11, 1, 1, 1);
    drive(1, 1, 0, 2); peek("mask_manual", 8'h12, 2, 1, 0);
    m_mask = '1;
    drive(1, 1, 1, 0); peek("mask_all", 8'h00, 0, 0, 0);
    drive(1, 1, 0, 0);
    m_mask = '0;
`endif

    mode_r = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 19) == 0) mode_r = ~mode_r;
`ifdef MUXN_SCAN_MASK_EN
      if (m_st != 2 && $urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: m_mask = '0;
          1: m_mask = '1;
          default: m_mask = N'($urandom());
        endcase
      end
`endif
      if ($urandom_range(0, 1) == 0)
        for (int k = 0; k < N; k++) x[k*W +: W] = W'($urandom_range(0, 255));
      n_reset = ($urandom_range(0, 99) != 0);
      en      = ($urandom_range(0, 4) != 0);
      mode    = mode_r;
      sel     = SW'($urandom_range(0, (1 << SW) - 1));
      step_model();
    end
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muxn_scan.md
MUXN_SCAN -- requirements
Module: muxn_scan

Interface
REQ-001 Parameter N, default 4: channel count, 2..16.
REQ-002 Parameter W, default 1: data width per channel, 1..32.
REQ-003 Parameter DWELL, default 1: clock cycles spent on each channel in scan mode, 1..255.
REQ-004 SW = $clog2(N), the width of select and channel index.
REQ-005 clk  input  1  single clock, rising edge.
REQ-006 n_reset  input  1  reset, synchronous, active-low.
REQ-007 x  input  N*W  packed data; channel k occupies bits [k*W +: W].
REQ-008 sel  input  SW  manual channel select.
REQ-009 mode  input  1  0 = manual, 1 = scan.
REQ-010 en  input  1  advance/update enable.
REQ-011 y  output  W  registered selected data.
REQ-012 ch  output  SW  channel index that produced y.
REQ-013 valid  output  1  y/ch hold a legitimate sample.
REQ-014 wrap  output  1  one-cycle pulse when scan index wraps from N-1 to 0.

Function
REQ-015 All outputs are registered; latency from input change to y is 1 clock.
REQ-016 Manual mode with en=1: each clk, y <= x[sel*W +: W], ch <= sel, valid <= 1.
REQ-017 Manual mode with sel >= N (non-power-of-2 N): y <= 0, ch <= sel, valid <= 0.
REQ-018 FSM states: IDLE, MANUAL, SCAN; IDLE after reset; with en=1, mode selects MANUAL or SCAN on the next edge.
REQ-019 SCAN: index idx and dwell counter dcnt; each en=1 cycle, y <= x[idx], ch <= idx, valid <= 1.
REQ-020 SCAN: dcnt counts 0..DWELL-1; when dcnt = DWELL-1, dcnt <= 0 and idx <= idx+1, or 0 if idx = N-1.
REQ-021 wrap = 1 for exactly the cycle after idx changes from N-1 to 0; otherwise 0.
REQ-022 Entry into SCAN from IDLE or MANUAL starts at idx = 0, dcnt = 0.
REQ-023 Scan to manual switch (mode 1->0): the next edge uses sel, and idx/dcnt reset to 0.
REQ-024 en = 0 in any state: y, ch, valid, idx and dcnt hold; wrap = 0.
REQ-025 DWELL = 1: idx advances on every en=1 cycle.
REQ-026 Changes on x while in SCAN are sampled on each cycle, not latched per dwell.

Reset
REQ-027 When n_reset = 0 at a rising edge: y = 0, ch = 0, valid = 0, wrap = 0, idx = 0, dcnt = 0, state = IDLE.
REQ-028 Reset applied mid-scan or mid-dwell takes priority over en and mode.
REQ-029 The first post-reset sample appears one edge after entering MANUAL or SCAN.

Configuration
REQ-030 Macro MUXN_SCAN_MASK_EN, when defined, adds input mask (N bits); mask[k] = 1 excludes channel k from scanning.
REQ-031 With the macro defined, a SCAN advance skips masked channels to the next unmasked index, in increasing order with wrap-around.
REQ-032 With the macro defined, wrap pulses whenever the advance passes through index N-1.
REQ-033 With the macro defined and mask = all ones, SCAN drives valid = 0 and y = 0, and idx holds.
REQ-034 With the macro defined, the mask has no effect in MANUAL mode.
REQ-035 Without the macro, there is no mask port and all channels are scanned.

Verification
REQ-036 N=4, W=1, x=4'b1101, manual, sel=0..3 -> y after 1 clk = 1, 0, 1, 1; valid = 1; ch = sel.
REQ-037 N=8, W=8, x[k]=8'h10+k, scan, DWELL=1 -> y = 10..17, then 10; wrap pulses with ch = 0.
REQ-038 N=4, DWELL=3, scan -> each ch is held 3 cycles; wrap every 12 cycles.
REQ-039 Scan at idx=2, mode -> 0, sel=1 -> next y = x[1], ch = 1; mode -> 1 -> restarts at ch = 0.
REQ-040 en = 0 for 5 cycles mid-dwell -> outputs frozen and wrap = 0; resumes at the same idx/dcnt.
REQ-041 n_reset = 0 mid-scan -> next edge all outputs are 0 and state = IDLE; with MUXN_SCAN_MASK_EN and mask = 4'b0101 -> scan order 1, 3, 1.
